// File: rtl/calc_defs.sv
// Shared definitions for the pocket-calculator CPU.
//   - FSM state encoding used by the fetch unit (visible on its debug port).
//   - Address / instruction width constants.
//   - Instruction field positions and a helper that extracts the branch
//     address (BA) field from an instruction word.
package calc_defs;

    localparam int CALC_ADDR_W  = 10;
    localparam int CALC_INSTR_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_e;

    // Instruction field positions
    localparam int OPCODE_MSB   = 15;
    localparam int OPCODE_LSB   = 10;
    localparam int REG_ADDR_BIT = 9;
    localparam int SREG_MSB     = 9;
    localparam int SREG_LSB     = 8;
    localparam int IMM_MSB      = 8;
    localparam int IMM_LSB      = 0;
    localparam int BA_MSB       = 9;
    localparam int BA_LSB       = 0;

    function automatic logic [CALC_ADDR_W-1:0] ba_field(input logic [CALC_INSTR_W-1:0] instr);
        return instr[BA_MSB:BA_LSB];
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter register.
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset (pc <= RESET_VAL)
//   load_i      load load_val_i (branch); has priority over inc_i
//   load_val_i  branch target
//   inc_i       increment by one, wrapping modulo 2^ADDR_W
//   pc_o        current program counter
module pc_counter #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the pocket-calculator CPU. Holds the PC, fetches one word
// per request/ack handshake and presents it to the instruction register with
// a one-cycle IR_LOAD pulse.
//
// Memory handshake: MEM_REQ is held high for the whole FETCH state with
// MEM_ADDR = PC; a word is accepted on the first rising edge where MEM_ACK is
// high while MEM_REQ is high. A request is never withdrawn before its ack
// (except by the optional watchdog or by reset).
//
// Ports:
//   CLK, RESET            clock, asynchronous active-low reset
//   START                 leave IDLE and start fetching
//   MEM_REQ/MEM_ADDR      request and address to instruction memory
//   MEM_ACK/MEM_DATA      ack and instruction word from memory
//   IR_DATA/IR_LOAD       last fetched word and its load pulse
//   NEXT/BRANCH/BRANCH_ADDR/HALT  control-unit commands
//   PC                    program counter
//   BUSY                  high in FETCH and EXEC
//   FETCH_ERR             sticky watchdog flag (FETCH_TIMEOUT_EN build only)
//   STATE_DBG             current FSM state
//
// Build option: define FETCH_TIMEOUT_EN to add the fetch watchdog.
module instruction_fetch_unit
    import calc_defs::*;
#(
    parameter int                ADDR_W         = CALC_ADDR_W,
    parameter int                INSTR_W        = CALC_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int                TIMEOUT_CYCLES = 15
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    output logic               MEM_REQ,
    output logic [ADDR_W-1:0]  MEM_ADDR,
    input  logic               MEM_ACK,
    input  logic [INSTR_W-1:0] MEM_DATA,
    output logic [INSTR_W-1:0] IR_DATA,
    output logic               IR_LOAD,
    input  logic               NEXT,
    input  logic               BRANCH,
    input  logic [ADDR_W-1:0]  BRANCH_ADDR,
    input  logic               HALT,
    output logic [ADDR_W-1:0]  PC,
`ifdef FETCH_TIMEOUT_EN
    output logic               FETCH_ERR,
`endif
    output logic               BUSY,
    output logic [1:0]         STATE_DBG
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_data_q, ir_data_d;
    logic               ir_load_q, ir_load_d;
    // Remembers a HALT seen during FETCH so it takes effect at the ack even
    // if the control unit has already dropped it.
    logic               halt_pend_q, halt_pend_d;
    logic               pc_load;
    logic               pc_inc;
    logic               mem_req;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       fetch_err_q, fetch_err_d;
`else
    // The watchdog limit only matters when the watchdog is built in.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    pc_counter #(
        .ADDR_W    (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk_i      (CLK),
        .rst_ni     (RESET),
        .load_i     (pc_load),
        .load_val_i (BRANCH_ADDR),
        .inc_i      (pc_inc),
        .pc_o       (PC)
    );

    always_comb begin
        state_d     = state_q;
        ir_data_d   = ir_data_q;
        ir_load_d   = 1'b0;
        halt_pend_d = halt_pend_q;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        mem_req     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        fetch_err_d = fetch_err_q;
`endif
        case (state_q)
            IDLE: begin
                halt_pend_d = 1'b0;
                if (HALT) begin
                    state_d = HALTED;
                end else if (START) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_req = 1'b1;
                if (HALT) begin
                    halt_pend_d = 1'b1;
                end
                if (MEM_ACK) begin
                    ir_data_d   = MEM_DATA;
                    ir_load_d   = 1'b1;
                    pc_inc      = 1'b1;
                    halt_pend_d = 1'b0;
                    state_d     = (halt_pend_q || HALT) ? HALTED : EXEC;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_cnt_q == 4'(TIMEOUT_CYCLES - 1)) begin
                    // This cycle is the last one allowed without an ack.
                    fetch_err_d = 1'b1;
                    halt_pend_d = 1'b0;
                    state_d     = HALTED;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
`endif
            end
            EXEC: begin
                if (HALT) begin
                    state_d = HALTED;
                end else if (BRANCH) begin
                    pc_load = 1'b1;
                    state_d = FETCH;
                end else if (NEXT) begin
                    state_d = FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef FETCH_TIMEOUT_EN
        if (state_d == FETCH && state_q != FETCH) begin
            wait_cnt_d = 4'd0;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            ir_data_q   <= '0;
            ir_load_q   <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_data_q   <= ir_data_d;
            ir_load_q   <= ir_load_d;
            halt_pend_q <= halt_pend_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wait_cnt_q  <= 4'd0;
            fetch_err_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign FETCH_ERR = fetch_err_q;
`endif

    assign MEM_REQ   = mem_req;
    assign MEM_ADDR  = PC;
    assign IR_DATA   = ir_data_q;
    assign IR_LOAD   = ir_load_q;
    assign BUSY      = (state_q == FETCH) || (state_q == EXEC);
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic        MEM_REQ;
  logic [9:0]  MEM_ADDR;
  logic        MEM_ACK;
  logic [15:0] MEM_DATA;
  logic [15:0] IR_DATA;
  logic        IR_LOAD;
  logic        NEXT;
  logic        BRANCH;
  logic [9:0]  BRANCH_ADDR;
  logic        HALT;
  logic [9:0]  PC;
  logic        BUSY;
  logic [1:0]  STATE_DBG;
`ifdef FETCH_TIMEOUT_EN
  logic        FETCH_ERR;
`endif

  int n_checks = 0;
  int n_fail = 0;

  instruction_fetch_unit dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .START       (START),
    .MEM_REQ     (MEM_REQ),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_ACK     (MEM_ACK),
    .MEM_DATA    (MEM_DATA),
    .IR_DATA     (IR_DATA),
    .IR_LOAD     (IR_LOAD),
    .NEXT        (NEXT),
    .BRANCH      (BRANCH),
    .BRANCH_ADDR (BRANCH_ADDR),
    .HALT        (HALT),
    .PC          (PC),
`ifdef FETCH_TIMEOUT_EN
    .FETCH_ERR   (FETCH_ERR),
`endif
    .BUSY        (BUSY),
    .STATE_DBG   (STATE_DBG)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        start;
    logic        ack;
    logic [15:0] data;
    logic        next;
    logic        branch;
    logic [9:0]  ba;
    logic        halt;
    logic        exp_req;
    logic [9:0]  exp_addr;
    logic [15:0] exp_ir;
    logic        exp_load;
    logic [9:0]  exp_pc;
    logic        exp_busy;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    START = 1'b0; MEM_ACK = 1'b0; MEM_DATA = 16'h0; NEXT = 1'b0;
    BRANCH = 1'b0; BRANCH_ADDR = 10'h0; HALT = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    drive_idle();
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".req"},   32'(MEM_REQ),   32'h0);
    check({tag, ".addr"},  32'(MEM_ADDR),  32'h0);
    check({tag, ".ir"},    32'(IR_DATA),   32'h0);
    check({tag, ".load"},  32'(IR_LOAD),   32'h0);
    check({tag, ".pc"},    32'(PC),        32'h0);
    check({tag, ".busy"},  32'(BUSY),      32'h0);
    check({tag, ".state"}, 32'(STATE_DBG), 32'h0);
`ifdef FETCH_TIMEOUT_EN
    check({tag, ".err"},   32'(FETCH_ERR), 32'h0);
`endif
  endtask

  initial begin
    RESET = 1'b0;
    drive_idle();

    //                start ack data      nxt br ba      halt | req addr    ir        ld pc      busy st
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 16'h0000, 1'b0, 10'h000, 1'b1, 2'd1};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 16'h0000, 1'b0, 10'h000, 1'b1, 2'd1};
    vecs[2]  = '{1'b0, 1'b1, 16'h6AB3, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h001, 16'h6AB3, 1'b1, 10'h001, 1'b1, 2'd2};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h001, 16'h6AB3, 1'b0, 10'h001, 1'b1, 2'd2};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h001, 16'h6AB3, 1'b0, 10'h001, 1'b1, 2'd1};
    vecs[5]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h002, 16'h1234, 1'b1, 10'h002, 1'b1, 2'd2};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 10'h2B3, 1'b0, 1'b1, 10'h2B3, 16'h1234, 1'b0, 10'h2B3, 1'b1, 2'd1};
    vecs[7]  = '{1'b0, 1'b1, 16'h0A0A, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h2B4, 16'h0A0A, 1'b1, 10'h2B4, 1'b1, 2'd2};
    vecs[8]  = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h2B4, 16'h0A0A, 1'b0, 10'h2B4, 1'b1, 2'd2};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 10'h3FF, 1'b0, 1'b1, 10'h3FF, 16'h0A0A, 1'b0, 10'h3FF, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 16'h5555, 1'b1, 10'h000, 1'b1, 2'd2};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 16'h5555, 1'b0, 10'h000, 1'b1, 2'd1};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h000, 16'h5555, 1'b0, 10'h000, 1'b1, 2'd1};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 16'h5555, 1'b0, 10'h000, 1'b1, 2'd1};
    vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 16'h5555, 1'b0, 10'h000, 1'b1, 2'd1};
    vecs[15] = '{1'b0, 1'b1, 16'h16F4, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h001, 16'h16F4, 1'b1, 10'h001, 1'b0, 2'd3};
    vecs[16] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 10'h001, 16'h16F4, 1'b0, 10'h001, 1'b0, 2'd3};
    vecs[17] = '{1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1, 10'h155, 1'b0, 1'b0, 10'h001, 16'h16F4, 1'b0, 10'h001, 1'b0, 2'd3};

    // power-on reset
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    #1;
    check_reset_state("por");

    // main table
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      START = vecs[i].start; MEM_ACK = vecs[i].ack; MEM_DATA = vecs[i].data;
      NEXT = vecs[i].next; BRANCH = vecs[i].branch; BRANCH_ADDR = vecs[i].ba;
      HALT = vecs[i].halt;
      step();
      check($sformatf("v%0d.req", i),   32'(MEM_REQ),   32'(vecs[i].exp_req));
      check($sformatf("v%0d.addr", i),  32'(MEM_ADDR),  32'(vecs[i].exp_addr));
      check($sformatf("v%0d.ir", i),    32'(IR_DATA),   32'(vecs[i].exp_ir));
      check($sformatf("v%0d.load", i),  32'(IR_LOAD),   32'(vecs[i].exp_load));
      check($sformatf("v%0d.pc", i),    32'(PC),        32'(vecs[i].exp_pc));
      check($sformatf("v%0d.busy", i),  32'(BUSY),      32'(vecs[i].exp_busy));
      check($sformatf("v%0d.state", i), 32'(STATE_DBG), 32'(vecs[i].exp_state));
    end

    // reset clears HALTED and IR_DATA
    do_reset();
    #1;
    check_reset_state("rst_halted");

    // asynchronous reset in the middle of a FETCH cycle
    @(negedge CLK);
    START = 1'b1;
    step();
    START = 1'b0;
    check("mid.req_before", 32'(MEM_REQ), 32'h1);
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    check_reset_state("async");
    @(negedge CLK);
    RESET = 1'b1;

    // HALT in IDLE wins over START; HALTED ignores START afterwards
    @(negedge CLK);
    HALT = 1'b1; START = 1'b1;
    step();
    check("idle_halt.state", 32'(STATE_DBG), 32'd3);
    check("idle_halt.busy",  32'(BUSY),      32'h0);
    @(negedge CLK);
    HALT = 1'b0;
    step();
    check("idle_halt.req",   32'(MEM_REQ),   32'h0);
    check("idle_halt.stay",  32'(STATE_DBG), 32'd3);

    // HALT beats BRANCH in EXEC; PC is not redirected
    do_reset();
    @(negedge CLK);
    START = 1'b1;
    step();
    @(negedge CLK);
    START = 1'b0; MEM_ACK = 1'b1; MEM_DATA = 16'hC0DE;
    step();
    check("exec.state", 32'(STATE_DBG), 32'd2);
    @(negedge CLK);
    MEM_ACK = 1'b0; HALT = 1'b1; BRANCH = 1'b1; BRANCH_ADDR = 10'h0AA;
    step();
    check("exec_halt.state", 32'(STATE_DBG), 32'd3);
    check("exec_halt.pc",    32'(PC),        32'h001);
    check("exec_halt.ir",    32'(IR_DATA),   32'hC0DE);

    // a fetch that never gets an ack
    do_reset();
    @(negedge CLK);
    START = 1'b1;
    step();
    @(negedge CLK);
    START = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    repeat (14) step();
    check("to.req_14",   32'(MEM_REQ),   32'h1);
    check("to.err_14",   32'(FETCH_ERR), 32'h0);
    step();
    check("to.req_15",   32'(MEM_REQ),   32'h0);
    check("to.err_15",   32'(FETCH_ERR), 32'h1);
    check("to.load",     32'(IR_LOAD),   32'h0);
    check("to.ir",       32'(IR_DATA),   32'h0);
    check("to.state",    32'(STATE_DBG), 32'd3);
    repeat (3) step();
    check("to.err_sticky", 32'(FETCH_ERR), 32'h1);
`else
    repeat (100) step();
    check("noack.req",   32'(MEM_REQ),   32'h1);
    check("noack.state", 32'(STATE_DBG), 32'd1);
    check("noack.load",  32'(IR_LOAD),   32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
